// File: rtl/zmod_pkg.sv
// Shared types and defaults for the Zmod serial link receive path.
package zmod_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SLIP,
    WAIT,
    LOCKED,
    FAIL
  } align_state_t;

  localparam int          ZMOD_WORD_W     = 8;
  localparam logic [7:0]  ZMOD_TRAIN_WORD = 8'h0F;

endpackage

// File: rtl/zmod_rx_align.sv
// Receive word aligner for the Zmod link, placed after a 1:8 ISERDES.
// Once the PLL is locked it hunts for the training word. It steps the
// ISERDES phase with single-cycle bitslip pulses until the word repeats
// MATCH_COUNT times, then forwards aligned data. It flags failure once
// every phase has been tried without a match.
module zmod_rx_align
  import zmod_pkg::*;
#(
  parameter int             W             = ZMOD_WORD_W,
  parameter logic [W-1:0]   TRAIN_PATTERN = W'(ZMOD_TRAIN_WORD),
  parameter int             MATCH_COUNT   = 16,
  parameter int             SLIP_WAIT     = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 pll_locked,
  input  logic                 align_start,
  input  logic [W-1:0]         din,
  output logic                 bitslip,
  output logic [W-1:0]         dout,
  output logic                 dout_valid,
  output logic                 aligned,
  output logic                 align_fail,
  output logic [$clog2(W)-1:0] slip_count
);

  localparam int SCW = $clog2(W);
  localparam int MCW = $clog2(MATCH_COUNT + 1);
  localparam int WCW = $clog2(SLIP_WAIT + 1);

  localparam logic [SCW-1:0] SLIP_MAX   = SCW'(W - 1);
  localparam logic [MCW-1:0] MATCH_LAST = MCW'(MATCH_COUNT - 1);
  localparam logic [MCW-1:0] MATCH_SAT  = MCW'(MATCH_COUNT);
  localparam logic [WCW-1:0] WAIT_LOAD  = WCW'(SLIP_WAIT);
  localparam logic [WCW-1:0] WAIT_ONE   = WCW'(1);

  align_state_t   state, state_n;
  logic [MCW-1:0] match_cnt, match_n;
  logic [WCW-1:0] wait_cnt, wait_n;
  logic [SCW-1:0] slip_n;

  // Next-state and counter logic. Losing PLL lock overrides every other transition.
  always_comb begin
    state_n = state;
    match_n = match_cnt;
    wait_n  = wait_cnt;
    slip_n  = slip_count;
    if (state != IDLE && !pll_locked) begin
      state_n = IDLE;
      match_n = '0;
      wait_n  = '0;
      slip_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (align_start && pll_locked) begin
            state_n = CHECK;
            match_n = '0;
            slip_n  = '0;
          end
        end
        CHECK: begin
          if (din == TRAIN_PATTERN) begin
            if (match_cnt >= MATCH_LAST) begin
              state_n = LOCKED;
              match_n = MATCH_SAT;
            end else begin
              match_n = match_cnt + 1'b1;
            end
          end else begin
            match_n = '0;
            if (slip_count < SLIP_MAX) begin
              // Count the slip as it is issued, so it lines up with the pulse.
              state_n = SLIP;
              slip_n  = slip_count + 1'b1;
            end else begin
              state_n = FAIL;
            end
          end
        end
        SLIP: begin
          state_n = WAIT;
          wait_n  = WAIT_LOAD;
        end
        WAIT: begin
          // Leave on the decrement that reaches zero. The first compare then
          // lands SLIP_WAIT+1 cycles after the bitslip cycle.
          if (wait_cnt <= WAIT_ONE) begin
            wait_n  = '0;
            state_n = CHECK;
          end else begin
            wait_n = wait_cnt - 1'b1;
          end
        end
        LOCKED, FAIL: begin
          if (align_start) begin
            state_n = CHECK;
            match_n = '0;
            wait_n  = '0;
            slip_n  = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, counters and registered outputs. Status flags come from the next
  // state, so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      match_cnt  <= '0;
      wait_cnt   <= '0;
      slip_count <= '0;
      bitslip    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      aligned    <= 1'b0;
      align_fail <= 1'b0;
    end else begin
      state      <= state_n;
      match_cnt  <= match_n;
      wait_cnt   <= wait_n;
      slip_count <= slip_n;
      bitslip    <= (state_n == SLIP);
      dout_valid <= (state_n == LOCKED);
      aligned    <= (state_n == LOCKED);
      align_fail <= (state_n == FAIL);
      if (state_n == LOCKED) dout <= din;
    end
  end

endmodule
